// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS sweep controller and DDS_phaser register decode.
// Register map, FSM state encoding and the dwell clamp helper.
package dds_ctrl_pkg;

    localparam int DDS_FREQ_ADDR  = 'h20;
    localparam int DDS_PHASE_ADDR = 'h30;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_PHASE,
        S_GAP,
        S_WR_FREQ,
        S_DWELL,
        S_DONE
    } state_t;

    // A dwell of zero cycles would break the write/gap rule, so it means one.
    function automatic int unsigned dwell_clamp(input int unsigned d);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
// Shared by sweep, hop and chirp style controllers.
module dds_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && value != '0) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: one phase write, then N+1 frequency writes
// each followed by a programmable dwell, driving the DDS register bus.
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int FREQ_ADDR  = DDS_FREQ_ADDR,
    parameter int PHASE_ADDR = DDS_PHASE_ADDR,
    parameter int NSTEP_W    = 12,
    parameter int DWELL_W    = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [DW-1:0]      cfg_fstart,
    input  logic [DW-1:0]      cfg_fstep,
    input  logic [NSTEP_W-1:0] cfg_nsteps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [DW-1:0]      cfg_phase,
    output logic               busy,
    output logic               done,
    output logic [NSTEP_W-1:0] step_idx,
    output logic               wr,
    output logic [AW-1:0]      waddr,
    output logic [DW-1:0]      wdata
);

    state_t state, state_nx;

    logic [DW-1:0]      fstep_q;
    logic [NSTEP_W-1:0] nsteps_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DW-1:0]      freq, freq_nx;
    logic               latch;

    logic               busy_nx, done_nx, wr_nx;
    logic [AW-1:0]      waddr_nx;
    logic [DW-1:0]      wdata_nx;
    logic [NSTEP_W-1:0] step_nx;

    logic               t_load, t_en, t_zero;
    logic [DWELL_W-1:0] t_value;

    dds_dwell_timer #(
        .W(DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rstn     (rstn),
        .load     (t_load),
        .load_val (dwell_q),
        .en       (t_en),
        .value    (t_value),
        .zero     (t_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy_nx  = busy;
        done_nx  = 1'b0;
        wr_nx    = 1'b0;
        waddr_nx = '0;
        wdata_nx = '0;
        step_nx  = step_idx;
        freq_nx  = freq;
        latch    = 1'b0;
        t_load   = 1'b0;
        t_en     = 1'b0;
        if (abort && state != S_IDLE) begin
            state_nx = S_IDLE;
            busy_nx  = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_nx = S_WR_PHASE;
                        busy_nx  = 1'b1;
                        wr_nx    = 1'b1;
                        waddr_nx = AW'(PHASE_ADDR);
                        wdata_nx = cfg_phase;
                        freq_nx  = cfg_fstart;
                        latch    = 1'b1;
                    end
                end
                S_WR_PHASE: state_nx = S_GAP;
                S_GAP: begin
                    state_nx = S_WR_FREQ;
                    wr_nx    = 1'b1;
                    waddr_nx = AW'(FREQ_ADDR);
                    wdata_nx = freq;
                    step_nx  = '0;
                end
                S_WR_FREQ: begin
                    state_nx = S_DWELL;
                    t_load   = 1'b1;
                end
                S_DWELL: begin
                    t_en = 1'b1;
                    if (t_zero) begin
                        if (step_idx == nsteps_q) begin
                            state_nx = S_DONE;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = S_WR_FREQ;
                            wr_nx    = 1'b1;
                            waddr_nx = AW'(FREQ_ADDR);
                            wdata_nx = freq + fstep_q;
                            freq_nx  = freq + fstep_q;
                            step_nx  = step_idx + NSTEP_W'(1);
                        end
                    end
                end
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fstep_q  <= '0;
            nsteps_q <= '0;
            dwell_q  <= '0;
        end else if (latch) begin
            fstep_q  <= cfg_fstep;
            nsteps_q <= cfg_nsteps;
            // Stored as D-1: the timer reload value for each dwell.
            dwell_q  <= DWELL_W'(dwell_clamp(32'(cfg_dwell)) - 1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            wr       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            step_idx <= '0;
            freq     <= '0;
        end else begin
            busy     <= busy_nx;
            done     <= done_nx;
            wr       <= wr_nx;
            waddr    <= waddr_nx;
            wdata    <= wdata_nx;
            step_idx <= step_nx;
            freq     <= freq_nx;
        end
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer that configures DDS_phaser through its register write bus (wr/waddr/wdata). On a start pulse it latches a sweep configuration, writes the phase offset once, then writes a series of frequency words. Each frequency word is held for a programmable dwell time. The block sits between the host/config logic and DDS_phaser and is the only master on the DDS write bus.

Parameters:
AW, 16, DDS register address width
DW, 16, DDS register data width
FREQ_ADDR, 16'h20, DDS frequency-word register address
PHASE_ADDR, 16'h30, DDS phase-offset register address
NSTEP_W, 12, width of step count and step index
DWELL_W, 16, width of dwell counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle sweep request
abort  in  1  one-cycle sweep cancel
cfg_fstart  in  DW  first frequency word
cfg_fstep  in  DW  frequency increment, two's complement
cfg_nsteps  in  NSTEP_W  number of increments; total frequency writes = N+1
cfg_dwell  in  DWELL_W  dwell cycles per frequency point; 0 treated as 1
cfg_phase  in  DW  phase offset written once per sweep
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at normal completion
step_idx  out  NSTEP_W  index of the most recent frequency write
wr  out  1  DDS register write strobe
waddr  out  AW  DDS register address
wdata  out  DW  DDS register data

Behaviour:
- Reset (async, rstn=0):
  - FSM goes to IDLE.
  - busy, done, wr, waddr, wdata and step_idx are all 0.
  - Reset mid-sweep is immediate; no trailing write is issued.
- All outputs are registered.
- Bus rules:
  - wr is a single-cycle strobe.
  - Every write is followed by at least one cycle with wr=0.
  - waddr and wdata are 0 whenever wr=0.
- Configuration capture:
  - cfg_* is latched in the cycle start is sampled in IDLE.
  - cfg_* changes after that point are ignored until the next sweep.
  - start while busy is ignored.
- States: IDLE, WR_PHASE, GAP, WR_FREQ, DWELL, DONE.
- Timeline, with start sampled at edge T, D = max(cfg_dwell,1), N = cfg_nsteps:
  - IDLE: busy=1 from T+1.
  - WR_PHASE, cycle T+1: wr=1, waddr=PHASE_ADDR, wdata=cfg_phase.
  - GAP, cycle T+2: wr=0.
  - WR_FREQ, cycle T+3+k(D+1), k=0..N: wr=1, waddr=FREQ_ADDR, wdata=f_k, step_idx=k.
  - DWELL: D cycles with wr=0. Then:
    - if k<N: go to WR_FREQ with k+1;
    - else: go to DONE.
  - DONE, cycle T+3+(N+1)(D+1): done=1 and busy=0 in the same cycle, then return to IDLE.
  - A new start is accepted from the cycle after DONE.
- Arithmetic:
  - f_0 = cfg_fstart.
  - f_{k+1} = f_k + cfg_fstep, modulo 2^DW; wrap-around is silent and intended.
  - The step counter compares k==N. With N=0 there is a single frequency write, then dwell, then done.
- Abort:
  - In any non-IDLE state, abort moves the FSM to IDLE next cycle.
  - busy=0, wr=0, no done pulse.
  - The last completed write is left in the DDS.
  - step_idx holds its last value.
  - Abort in IDLE has no effect.
  - If start and abort are sampled in the same IDLE cycle, abort wins and no sweep starts.
- Dwell counter:
  - Loads D-1 on entry to DWELL and counts down.
  - Leaves DWELL when the count is 0 and not aborting.

Decomposition:
- Shared package dds_ctrl_pkg holds:
  - FREQ_ADDR and PHASE_ADDR constants, shared with DDS_phaser's register decode;
  - the state enum for the FSM;
  - the dwell-zero clamp function.
- One sub-module, dds_dwell_timer: a loadable down-counter with load, value and zero flag. It is reusable by future hop/chirp controllers.
- The FSM, frequency accumulator and bus register stay in dds_sweep_ctrl.

Test Plan:
- Reset then idle 20 cycles -> busy=0, done=0, wr=0, waddr=0, wdata=0 throughout.
- phase=16'h000F, fstart=16'h0100, fstep=16'h0010, N=3, D=4, start at T:
  - phase write 0x30/0x000F at T+1;
  - frequency writes 0x20 at T+3, T+8, T+13, T+18 with data 0x0100, 0x0110, 0x0120, 0x0130;
  - step_idx 0..3;
  - done pulse at T+23.
- fstart=16'hFFF0, fstep=16'h0020, N=2, D=0 (clamped to 1):
  - frequency writes at T+3, T+5, T+7 with data 0xFFF0, 0x0010, 0x0030;
  - done at T+9.
- fstep=16'hFFFF (−1), N=0, D=2 -> a single frequency write of fstart at T+3, then done at T+6.
- Abort and start handling:
  - abort pulsed 2 cycles after the second frequency write -> busy=0 next cycle, no further wr, no done;
  - start and abort in the same IDLE cycle -> no wr and busy stays 0;
  - start during busy -> ignored, and the original sweep timing is unchanged.
- rstn deasserted during DWELL -> all outputs 0 asynchronously; after release, a fresh start produces the full sequence from the phase write.
